// File: rtl/pe_packetizer_pkg.sv
// Shared definitions for the PE packetizer: FSM state encoding,
// header field offsets and the location of the header parity bit.
package pe_packetizer_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_HEADER  = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COLLECT = ST_COLLECT,
      HEADER  = ST_HEADER,
      PAYLOAD = ST_PAYLOAD
   } pkt_state_e;

   localparam int DEST_LSB  = 0;
   localparam int LEN_LSB   = 8;
   localparam int LEN_WIDTH = 8;
   localparam int SRC_LSB   = 16;
   localparam int SRC_WIDTH = 8;

   // The parity bit is always the top bit of the flit.
   function automatic int parity_bit_idx(input int data_width);
      return data_width - 1;
   endfunction

endpackage

// File: rtl/pe_packetizer_if.sv
// Handshake bundle between a PE and the packetizer, plus the packetizer's
// NoC-facing port. Signal names keep the i_/o_ prefixes as seen from the
// packetizer, so "slave" is the packetizer and "master" its environment.
interface pe_packetizer_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 2
);

   logic [DataWidth-1:0] i_pe_data;
   logic                 i_pe_data_valid;
   logic [AddrWidth-1:0] i_pe_dest;
   logic                 i_pe_last;
   logic                 o_pe_data_ready;
   logic [DataWidth-1:0] o_noc_data;
   logic                 o_noc_data_valid;
   logic                 i_noc_data_ready;

   modport slave (
      input  i_pe_data,
      input  i_pe_data_valid,
      input  i_pe_dest,
      input  i_pe_last,
      output o_pe_data_ready,
      output o_noc_data,
      output o_noc_data_valid,
      input  i_noc_data_ready
   );

   modport master (
      output i_pe_data,
      output i_pe_data_valid,
      output i_pe_dest,
      output i_pe_last,
      input  o_pe_data_ready,
      input  o_noc_data,
      input  o_noc_data_valid,
      output i_noc_data_ready
   );

endinterface

// File: rtl/pe_packetizer_pkt_fifo.sv
// Payload buffer for one packet: synchronous write, pointer-advancing read
// with the head entry always visible on o_rd_data. Depth must be a power of
// two (at least 2); an extra pointer bit separates full from empty.
module pkt_fifo #(
   parameter int DataWidth = 32,
   parameter int Depth     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_wr_en,
   input  logic [DataWidth-1:0] i_wr_data,
   input  logic                 i_rd_en,
   output logic [DataWidth-1:0] o_rd_data,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int PtrW = $clog2(Depth);
   localparam logic [PtrW:0] PtrOne = 1;

   logic [DataWidth-1:0] mem_q [Depth];
   logic [PtrW:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]        rd_ptr_q, rd_ptr_d;
   logic                 do_wr, do_rd;

   assign o_full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign o_empty   = (wr_ptr_q == rd_ptr_q);
   assign do_wr     = i_wr_en && !o_full;
   assign do_rd     = i_rd_en && !o_empty;
   assign o_rd_data = mem_q[rd_ptr_q[PtrW-1:0]];

   // Advance each pointer only on a legal write/read.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
   end

   // Pointer registers; reset empties the buffer and drops any partial packet.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge i_clk) begin
      if (do_wr) mem_q[wr_ptr_q[PtrW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/pe_packetizer.sv
// Store-and-forward packetizer: collects a PE packet into a buffer, then
// emits a header flit followed by the buffered payload on the NoC port.
// Header: dest in the low bits, flit count at [15:8], source id at [23:16].
// Optional build macro PKT_PARITY_EN puts even parity over the whole header
// flit into its top bit; without it that bit is 0.
module pe_packetizer
   import pe_packetizer_pkg::*;
#(
   parameter int         DataWidth = 32,
   parameter int         AddrWidth = 2,
   parameter int         Depth     = 16,
   parameter logic [7:0] SrcId     = 8'd0
) (
   input logic             i_clk,
   input logic             i_reset,
   pe_packetizer_if.slave  bus
);

   localparam logic [7:0] DepthCount = 8'(Depth);

   pkt_state_e           state_q, state_d;
   logic [7:0]           count_q, count_d;
   logic [AddrWidth-1:0] dest_q, dest_d;
   logic [DataWidth-1:0] noc_data_q, noc_data_d;
   logic                 noc_valid_q, noc_valid_d;

   logic                 fifo_wr, fifo_rd;
   logic [DataWidth-1:0] fifo_rd_data;
   logic                 fifo_full, fifo_empty;
   logic                 pe_ready, pe_fire, noc_fire;

   function automatic logic [DataWidth-1:0] build_header(
      input logic [AddrWidth-1:0] dest,
      input logic [7:0]           len
   );
      logic [DataWidth-1:0] hdr;
      hdr = '0;
      hdr[DEST_LSB +: AddrWidth] = dest;
      hdr[LEN_LSB +: LEN_WIDTH]  = len;
      hdr[SRC_LSB +: SRC_WIDTH]  = SrcId;
`ifdef PKT_PARITY_EN
      hdr[parity_bit_idx(DataWidth)] = ^hdr[DataWidth-2:0];
`else
      hdr[parity_bit_idx(DataWidth)] = 1'b0;
`endif
      return hdr;
   endfunction

   // The buffer never fills while collecting (a full packet is force-closed),
   // so the full term only guards against accepting into a full buffer.
   assign pe_ready = ((state_q == IDLE) || (state_q == COLLECT)) && !fifo_full;
   assign pe_fire  = bus.i_pe_data_valid && pe_ready;
   assign noc_fire = noc_valid_q && bus.i_noc_data_ready;

   assign bus.o_pe_data_ready  = pe_ready;
   assign bus.o_noc_data       = noc_data_q;
   assign bus.o_noc_data_valid = noc_valid_q;

   pkt_fifo #(
      .DataWidth (DataWidth),
      .Depth     (Depth)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (fifo_wr),
      .i_wr_data (bus.i_pe_data),
      .i_rd_en   (fifo_rd),
      .o_rd_data (fifo_rd_data),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty)
   );

   // Next-state logic; the output register is loaded one flit ahead so the
   // header and each payload flit appear without bubbles while ready is high.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      dest_d      = dest_q;
      noc_data_d  = noc_data_q;
      noc_valid_d = noc_valid_q;
      fifo_wr     = 1'b0;
      fifo_rd     = 1'b0;
      case (state_q)
         IDLE, COLLECT: begin
            if (pe_fire) begin
               fifo_wr = 1'b1;
               if (state_q == IDLE) begin
                  count_d = 8'd1;
                  dest_d  = bus.i_pe_dest;
               end else begin
                  count_d = count_q + 8'd1;
               end
               if (bus.i_pe_last || (count_d == DepthCount)) begin
                  state_d     = HEADER;
                  noc_valid_d = 1'b1;
                  noc_data_d  = build_header(dest_d, count_d);
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         HEADER: begin
            if (noc_fire) begin
               state_d    = PAYLOAD;
               noc_data_d = fifo_rd_data;
               fifo_rd    = 1'b1;
            end
         end
         PAYLOAD: begin
            if (noc_fire) begin
               if (fifo_empty) begin
                  state_d     = IDLE;
                  count_d     = 8'd0;
                  noc_valid_d = 1'b0;
                  noc_data_d  = '0;
               end else begin
                  noc_data_d = fifo_rd_data;
                  fifo_rd    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         dest_q      <= '0;
         noc_data_q  <= '0;
         noc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dest_q      <= dest_d;
         noc_data_q  <= noc_data_d;
         noc_valid_q <= noc_valid_d;
      end
   end

endmodule
